// File: rtl/pw_entry.sv
// Four-digit code entry: debounced KEY[1] stores SW[3:0] digits, SEND holds the code until acknowledged.
// Optional build macro PW_ENTRY_MASK_EN shows entered digits as dashes instead of hex glyphs.
module pw_entry #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic        CLOCK_50,
    input  logic [1:0]  KEY,
    input  logic [9:0]  SW,
    input  logic        code_ack,
    output logic [15:0] code_out,
    output logic        code_valid,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX0,
    output logic [2:0]  LEDR
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic {ENTRY, SEND} state_t;

    logic          rst_n;
    logic          key_s1, key_s2, key_deb, press;
    logic [CW-1:0] deb_cnt;

    state_t         state, state_n;
    logic [3:0][3:0] dig_q, dig_n;      // dig_q[0] is the first digit entered
    logic [1:0]      cnt_q, cnt_n;
    logic [15:0]     code_q, code_n;
    logic            valid_q, valid_n;
    logic [3:0][6:0] hex_q, hex_n;

    assign rst_n = KEY[0];

    function automatic logic [6:0] glyph(input logic [3:0] d);
`ifdef PW_ENTRY_MASK_EN
        glyph = 7'b0111111;
`else
        case (d)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
`endif
    endfunction

    // Debounced level follows the synchronized key only after a full run of
    // DEBOUNCE_CYCLES differing samples; the falling transition emits press.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_deb <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= KEY[1];
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 != key_deb) begin
                if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    key_deb <= key_s2;
                    deb_cnt <= '0;
                    press   <= key_deb;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state   <= ENTRY;
            dig_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            hex_q   <= {4{BLANK}};
        end else begin
            state   <= state_n;
            dig_q   <= dig_n;
            cnt_q   <= cnt_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            hex_q   <= hex_n;
        end
    end

    always_comb begin
        state_n = state;
        dig_n   = dig_q;
        cnt_n   = cnt_q;
        code_n  = code_q;
        valid_n = valid_q;
        hex_n   = {4{BLANK}};
        case (state)
            ENTRY: begin
                if (SW[9]) begin
                    dig_n = '0;
                    cnt_n = '0;
                end else if (press) begin
                    dig_n[cnt_q] = SW[3:0];
                    if (cnt_q == 2'd3) begin
                        state_n = SEND;
                        code_n  = {dig_n[0], dig_n[1], dig_n[2], dig_n[3]};
                        valid_n = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 2'd1;
                    end
                end
            end
            SEND: begin
                if (code_ack) begin
                    state_n = ENTRY;
                    dig_n   = '0;
                    cnt_n   = '0;
                    code_n  = '0;
                    valid_n = 1'b0;
                end
            end
            default: state_n = ENTRY;
        endcase
        // Display is derived from next-state values so it lands on the storing edge.
        for (int i = 0; i < 4; i++) begin
            if (state_n == SEND || 2'(i) < cnt_n)
                hex_n[i] = glyph(dig_n[i]);
        end
    end

    assign code_out   = code_q;
    assign code_valid = valid_q;
    assign HEX3       = hex_q[0];
    assign HEX2       = hex_q[1];
    assign HEX1       = hex_q[2];
    assign HEX0       = hex_q[3];
    assign LEDR       = {state == SEND, cnt_q};

endmodule

// File: tb/tb_pw_entry.sv
// Directed bench for pw_entry with DEBOUNCE_CYCLES = 4; a behavioural model is compared every cycle.
module tb_pw_entry;

    localparam int N = 4;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic        clk = 1'b0;
    logic [1:0]  key;
    logic [9:0]  sw;
    logic        ack;
    logic [15:0] code_out;
    logic        code_valid;
    logic [6:0]  hex3, hex2, hex1, hex0;
    logic [2:0]  ledr;

    always #10 clk = ~clk;

    pw_entry #(.DEBOUNCE_CYCLES(N)) dut (
        .CLOCK_50(clk), .KEY(key), .SW(sw), .code_ack(ack),
        .code_out(code_out), .code_valid(code_valid),
        .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0), .LEDR(ledr)
    );

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model state: key delay line, debounced level and run length, code entry.
    logic       m_kd1, m_kd2, m_deb, m_press, m_p;
    int         m_run;
    logic [3:0] m_dig [4];
    int         m_cnt;
    logic       m_send;
    logic [15:0] m_code;

    function automatic logic [6:0] shown(input logic [3:0] d);
`ifdef PW_ENTRY_MASK_EN
        return DASH;
`else
        return glyph_tab[d];
`endif
    endfunction

    function automatic logic [6:0] dut_hex(input int i);
        case (i)
            0: return hex3;
            1: return hex2;
            2: return hex1;
            default: return hex0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!key[0]) begin
            m_kd1 = 1'b1; m_kd2 = 1'b1; m_deb = 1'b1; m_press = 1'b0; m_run = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            m_cnt = 0; m_send = 1'b0; m_code = 16'h0;
        end else begin
            m_p = m_press;
            m_press = 1'b0;
            if (m_kd2 != m_deb) begin
                m_run++;
                if (m_run == N) begin
                    m_press = m_deb;
                    m_deb = m_kd2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_kd2 = m_kd1;
            m_kd1 = key[1];
            if (!m_send) begin
                if (sw[9]) begin
                    m_cnt = 0;
                    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
                end else if (m_p) begin
                    m_dig[m_cnt] = sw[3:0];
                    if (m_cnt == 3) begin
                        m_send = 1'b1;
                        m_code = {m_dig[0], m_dig[1], m_dig[2], m_dig[3]};
                        m_cnt = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (ack) begin
                m_send = 1'b0;
                for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic press(input logic [3:0] v);
        @(negedge clk);
        sw[3:0] = v;
        key[1] = 1'b0;
        repeat (10) @(negedge clk);
        key[1] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        key = 2'b10; sw = '0; ack = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("model code_valid", 16'(code_valid), 16'(m_send));
                    chk("model LEDR", 16'(ledr), 16'({m_send, 2'(m_cnt)}));
                    if (m_send) chk("model code_out", code_out, m_code);
                    for (int i = 0; i < 4; i++)
                        chk($sformatf("model HEX digit%0d", i + 1), 16'(dut_hex(i)),
                            16'((m_send || i < m_cnt) ? shown(m_dig[i]) : BLANK));
                end
            end
        join_none

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset code_valid", 16'(code_valid), 16'h0);
        chk("reset code_out", code_out, 16'h0000);
        chk("reset HEX", {hex3[3:0], hex2[3:0], hex1[3:0], hex0[3:0]}, 16'hFFFF);
        chk("reset HEX hi", 16'({hex3[6:4], hex2[6:4], hex1[6:4], hex0[6:4]}), 16'h0FFF);
        chk("reset LEDR", 16'(ledr), 16'h0);
        key[0] = 1'b1;
        chk_en = 1'b1;

        // Clean entry of 1,2,3,4.
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("1234 code_out", code_out, 16'h1234);
        chk("1234 code_valid", 16'(code_valid), 16'h1);
        chk("1234 LEDR", 16'(ledr), 16'h4);
`ifndef PW_ENTRY_MASK_EN
        chk("1234 HEX3", 16'(hex3), 16'(7'b1111001));
        chk("1234 HEX0", 16'(hex0), 16'(7'b0011001));
`endif
        repeat (50) @(negedge clk);
        chk("1234 held", code_out, 16'h1234);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack code_valid", 16'(code_valid), 16'h0);
        chk("ack HEX3 blank", 16'(hex3), 16'(BLANK));

        // Bounce shorter than the debounce window.
        key[1] = 1'b0;
        repeat (2) @(negedge clk);
        key[1] = 1'b1;
        repeat (20) @(negedge clk);
        chk("bounce LEDR", 16'(ledr), 16'h0);
        press(4'h0);
        chk("after bounce LEDR", 16'(ledr), 16'h1);

        // Clear coinciding with a press.
        press(4'h5); press(4'h6);
        chk("pre-clear LEDR", 16'(ledr), 16'h3);
        sw[9] = 1'b1;
        press(4'hE);
        sw[9] = 1'b0;
        chk("clear LEDR", 16'(ledr), 16'h0);
        chk("clear HEX3 blank", 16'(hex3), 16'(BLANK));
        press(4'h9); press(4'hA); press(4'hB); press(4'hC);
        chk("9ABC code_out", code_out, 16'h9ABC);

        // Presses, clear and switch changes ignored in SEND; then reset.
        sw[9] = 1'b1;
        press(4'h3);
        sw[9] = 1'b0;
        press(4'h7);
        chk("send hold code_out", code_out, 16'h9ABC);
        chk("send hold valid", 16'(code_valid), 16'h1);
        key[1] = 1'b0;
        repeat (3) @(negedge clk);
        key[0] = 1'b0;
        @(negedge clk);
        chk("mid reset code_valid", 16'(code_valid), 16'h0);
        chk("mid reset code_out", code_out, 16'h0000);
        key = 2'b11;
        repeat (10) @(negedge clk);

        // Two digits: glyphs, or dashes with masking.
        press(4'h7); press(4'h7);
        chk("77 LEDR", 16'(ledr), 16'h2);
`ifdef PW_ENTRY_MASK_EN
        chk("77 HEX3", 16'(hex3), 16'(DASH));
        chk("77 HEX2", 16'(hex2), 16'(DASH));
`else
        chk("77 HEX3", 16'(hex3), 16'(7'b1111000));
        chk("77 HEX2", 16'(hex2), 16'(7'b1111000));
`endif
        chk("77 HEX1", 16'(hex1), 16'(BLANK));
        chk("77 HEX0", 16'(hex0), 16'(BLANK));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
